// File: rtl/am2911_seq_ctrl.sv
// Next-address controller for a cascade of Am2911 sequencer slices: decodes the
// microinstruction next-address field, runs the loop counter and tracks stack depth.
module am2911_seq_ctrl #(
  parameter int CW    = 8,
  parameter int DEPTH = 4,
  parameter int DW    = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [3:0]    op,
  input  logic          cc_n,
  input  logic          ccen_n,
  input  logic          hold,
  input  logic [CW-1:0] ct_load_val,
  output logic          s1,
  output logic          s0,
  output logic          zero_n,
  output logic          cin,
  output logic          re_n,
  output logic          fe_n,
  output logic          pup,
  output logic          pl_oe_n,
  output logic          map_oe_n,
  output logic          vect_oe_n,
  output logic          ct_zero,
  output logic [DW-1:0] depth,
  output logic          stack_ovf,
  output logic          stack_unf
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [DW-1:0] LP_DEPTH = DW'(DEPTH);

  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CJS  = 4'd1;
  localparam logic [3:0] OP_JMAP = 4'd2;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_CJV  = 4'd5;
  localparam logic [3:0] OP_LDCT = 4'd6;
  localparam logic [3:0] OP_RPCT = 4'd7;
  localparam logic [3:0] OP_CRTN = 4'd8;
  localparam logic [3:0] OP_LOOP = 4'd9;
  localparam logic [3:0] OP_TWB  = 4'd10;
  localparam logic [3:0] OP_JRP  = 4'd13;
  localparam logic [3:0] OP_LDAR = 4'd14;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_depth;
  logic          r_ovf;
  logic          r_unf;

  logic          w_pass;
  logic          w_ct_zero;
  logic [1:0]    w_sel;
  logic          w_zero_n;
  logic          w_cin;
  logic          w_re_n;
  logic          w_pl_oe_n;
  logic          w_map_oe_n;
  logic          w_vect_oe_n;
  logic          w_push;
  logic          w_pop;
  logic          w_load;
  logic          w_dec;

  assign w_pass    = ccen_n | ~cc_n;
  assign w_ct_zero = (r_cnt == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cnt <= ct_load_val;
      end else if (w_dec && !w_ct_zero) begin
        r_cnt <= r_cnt - CW'(1);
      end
      // The slices' stack wraps silently, so the depth saturates and the error sticks.
      if (w_push) begin
        if (r_depth == LP_DEPTH) r_ovf <= 1'b1;
        else                     r_depth <= r_depth + DW'(1);
      end else if (w_pop) begin
        if (r_depth == '0) r_unf <= 1'b1;
        else               r_depth <= r_depth - DW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    w_sel       = 2'b00;
    w_zero_n    = 1'b1;
    w_cin       = 1'b1;
    w_re_n      = 1'b1;
    w_pl_oe_n   = 1'b1;
    w_map_oe_n  = 1'b1;
    w_vect_oe_n = 1'b1;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;

    if (r_state == ST_INIT) begin
      w_zero_n = 1'b0;
    end else if (hold) begin
      // PC without carry: the slices re-emit the current address.
      w_cin = 1'b0;
    end else begin
      case (op)
        OP_JZ: w_zero_n = 1'b0;
        OP_CJS: begin
          if (w_pass) begin
            w_sel     = 2'b11;
            w_pl_oe_n = 1'b0;
            w_push    = 1'b1;
          end
        end
        OP_JMAP: begin
          w_sel      = 2'b11;
          w_map_oe_n = 1'b0;
        end
        OP_CJP: begin
          if (w_pass) begin
            w_sel     = 2'b11;
            w_pl_oe_n = 1'b0;
          end
        end
        OP_PUSH: begin
          w_push = 1'b1;
          w_load = w_pass;
        end
        OP_CJV: begin
          if (w_pass) begin
            w_sel       = 2'b11;
            w_vect_oe_n = 1'b0;
          end
        end
        OP_LDCT: w_load = 1'b1;
        OP_RPCT: begin
          if (!w_ct_zero) begin
            w_sel     = 2'b11;
            w_pl_oe_n = 1'b0;
            w_dec     = 1'b1;
          end
        end
        OP_CRTN: begin
          if (w_pass) begin
            w_sel = 2'b10;
            w_pop = 1'b1;
          end
        end
        OP_LOOP: begin
          if (w_pass) w_pop = 1'b1;
          else        w_sel = 2'b10;
        end
        OP_TWB: begin
          if (w_pass) begin
            w_pop = 1'b1;
          end else if (!w_ct_zero) begin
            w_sel = 2'b10;
            w_dec = 1'b1;
          end else begin
            w_sel     = 2'b11;
            w_pl_oe_n = 1'b0;
            w_pop     = 1'b1;
          end
        end
        OP_JRP: begin
          if (w_pass) begin
            w_sel     = 2'b11;
            w_pl_oe_n = 1'b0;
          end else begin
            w_sel = 2'b01;
          end
        end
        OP_LDAR: begin
          w_re_n    = 1'b0;
          w_pl_oe_n = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign s1        = w_sel[1];
  assign s0        = w_sel[0];
  assign zero_n    = w_zero_n;
  assign cin       = w_cin;
  assign re_n      = w_re_n;
  assign fe_n      = ~(w_push | w_pop);
  assign pup       = w_push;
  assign pl_oe_n   = w_pl_oe_n;
  assign map_oe_n  = w_map_oe_n;
  assign vect_oe_n = w_vect_oe_n;
  assign ct_zero   = w_ct_zero;
  assign depth     = r_depth;
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;

endmodule

// File: tb/tb_am2911_seq_ctrl.sv
// Directed-vector bench for am2911_seq_ctrl with hand-computed control words.
module tb_am2911_seq_ctrl;

  logic       clock;
  logic       reset_n;
  logic [3:0] op;
  logic       cc_n;
  logic       ccen_n;
  logic       hold;
  logic [7:0] ct_load_val;
  logic       s1, s0, zero_n, cin, re_n, fe_n, pup;
  logic       pl_oe_n, map_oe_n, vect_oe_n;
  logic       ct_zero;
  logic [2:0] depth;
  logic       stack_ovf, stack_unf;

  logic [31:0] ctlw;
  int          n_vec;
  int          n_err;

  am2911_seq_ctrl #(.CW(8), .DEPTH(4), .DW(3)) u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .op         (op),
    .cc_n       (cc_n),
    .ccen_n     (ccen_n),
    .hold       (hold),
    .ct_load_val(ct_load_val),
    .s1         (s1),
    .s0         (s0),
    .zero_n     (zero_n),
    .cin        (cin),
    .re_n       (re_n),
    .fe_n       (fe_n),
    .pup        (pup),
    .pl_oe_n    (pl_oe_n),
    .map_oe_n   (map_oe_n),
    .vect_oe_n  (vect_oe_n),
    .ct_zero    (ct_zero),
    .depth      (depth),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ctlw = {22'd0, s1, s0, zero_n, cin, re_n, fe_n, pup, pl_oe_n, map_oe_n, vect_oe_n};

  // Packs the expected control outputs in the same order as ctlw.
  function automatic logic [31:0] ctl(input int s, input int z, input int ci, input int re,
                                      input int fe, input int pu, input int pl, input int mp,
                                      input int vc);
    return 32'((s << 8) | (z << 7) | (ci << 6) | (re << 5) | (fe << 4) | (pu << 3) |
               (pl << 2) | (mp << 1) | vc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [3:0] o, input logic ccn, input logic hd, input logic [7:0] ld);
    op          = o;
    cc_n        = ccn;
    hold        = hd;
    ct_load_val = ld;
    #2;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  logic [31:0] CONT, INIT, HOLD, JPL, PUSHW, POPS;

  initial begin
    n_vec  = 0;
    n_err  = 0;
    CONT   = ctl(0, 1, 1, 1, 1, 0, 1, 1, 1);
    INIT   = ctl(0, 0, 1, 1, 1, 0, 1, 1, 1);
    HOLD   = ctl(0, 1, 0, 1, 1, 0, 1, 1, 1);
    JPL    = ctl(3, 1, 1, 1, 1, 0, 0, 1, 1);
    PUSHW  = ctl(0, 1, 1, 1, 0, 1, 1, 1, 1);
    POPS   = ctl(2, 1, 1, 1, 0, 0, 1, 1, 1);
    reset_n = 1'b0;
    ccen_n  = 1'b0;
    drv(4'd1, 1'b0, 1'b0, 8'd0);

    chk("rst_ctl", ctlw, INIT);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_ctzero", 32'(ct_zero), 1);
    chk("rst_flags", 32'({stack_ovf, stack_unf}), 0);
    tick();
    chk("rst_edge_ctl", ctlw, INIT);
    reset_n = 1'b1;
    drv(4'd11, 1'b0, 1'b0, 8'd0);
    chk("init_ctl", ctlw, INIT);
    tick();
    chk("run_op11", ctlw, CONT);

    drv(4'd1, 1'b0, 1'b0, 8'd0);
    chk("cjs_pass", ctlw, ctl(3, 1, 1, 1, 0, 1, 0, 1, 1));
    tick();
    chk("cjs_depth", 32'(depth), 1);
    drv(4'd8, 1'b0, 1'b0, 8'd0);
    chk("crtn_pass", ctlw, POPS);
    tick();
    chk("crtn_depth", 32'(depth), 0);
    drv(4'd1, 1'b1, 1'b0, 8'd0);
    chk("cjs_fail", ctlw, CONT);
    tick();
    chk("cjs_fail_depth", 32'(depth), 0);

    drv(4'd3, 1'b0, 1'b0, 8'd0);
    chk("cjp_pass", ctlw, JPL);
    drv(4'd3, 1'b1, 1'b0, 8'd0);
    chk("cjp_fail", ctlw, CONT);
    ccen_n = 1'b1;
    #1;
    chk("cjp_ccen_forced", ctlw, JPL);
    ccen_n = 1'b0;
    drv(4'd2, 1'b1, 1'b0, 8'd0);
    chk("jmap", ctlw, ctl(3, 1, 1, 1, 1, 0, 1, 0, 1));
    drv(4'd5, 1'b0, 1'b0, 8'd0);
    chk("cjv_pass", ctlw, ctl(3, 1, 1, 1, 1, 0, 1, 1, 0));
    drv(4'd0, 1'b1, 1'b0, 8'd0);
    chk("jz", ctlw, ctl(0, 0, 1, 1, 1, 0, 1, 1, 1));
    drv(4'd14, 1'b1, 1'b0, 8'd0);
    chk("ldar", ctlw, ctl(0, 1, 1, 0, 1, 0, 0, 1, 1));
    drv(4'd13, 1'b1, 1'b0, 8'd0);
    chk("jrp_fail", ctlw, ctl(1, 1, 1, 1, 1, 0, 1, 1, 1));
    drv(4'd13, 1'b0, 1'b0, 8'd0);
    chk("jrp_pass", ctlw, JPL);
    drv(4'd15, 1'b0, 1'b0, 8'd0);
    chk("op15", ctlw, CONT);

    drv(4'd6, 1'b1, 1'b0, 8'd3);
    chk("ldct", ctlw, CONT);
    tick();
    chk("ldct_ctzero", 32'(ct_zero), 0);
    drv(4'd7, 1'b1, 1'b0, 8'd0);
    chk("rpct_1", ctlw, JPL);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(4'd7, 1'b1, 1'b1, 8'd0);
      chk("hold_ctl", ctlw, HOLD);
      tick();
      chk("hold_ctzero", 32'(ct_zero), 0);
    end
    drv(4'd7, 1'b1, 1'b0, 8'd0);
    chk("rpct_2", ctlw, JPL);
    tick();
    drv(4'd7, 1'b1, 1'b0, 8'd0);
    chk("rpct_3", ctlw, JPL);
    tick();
    chk("rpct_ctzero", 32'(ct_zero), 1);
    drv(4'd7, 1'b1, 1'b0, 8'd0);
    chk("rpct_done", ctlw, CONT);

    drv(4'd4, 1'b0, 1'b0, 8'd1);
    chk("push_pass", ctlw, PUSHW);
    tick();
    chk("push_depth", 32'(depth), 1);
    chk("push_load", 32'(ct_zero), 0);
    drv(4'd10, 1'b1, 1'b0, 8'd0);
    chk("twb_dec", ctlw, ctl(2, 1, 1, 1, 1, 0, 1, 1, 1));
    tick();
    chk("twb_dec_ctzero", 32'(ct_zero), 1);
    chk("twb_dec_depth", 32'(depth), 1);
    drv(4'd10, 1'b1, 1'b0, 8'd0);
    chk("twb_exit", ctlw, ctl(3, 1, 1, 1, 0, 0, 0, 1, 1));
    tick();
    chk("twb_exit_depth", 32'(depth), 0);
    drv(4'd4, 1'b1, 1'b0, 8'd5);
    chk("push_fail", ctlw, PUSHW);
    tick();
    chk("push_noload", 32'(ct_zero), 1);
    drv(4'd10, 1'b0, 1'b0, 8'd0);
    chk("twb_pass", ctlw, ctl(0, 1, 1, 1, 0, 0, 1, 1, 1));
    tick();
    chk("twb_pass_depth", 32'(depth), 0);

    drv(4'd4, 1'b1, 1'b0, 8'd0);
    tick();
    drv(4'd9, 1'b1, 1'b0, 8'd0);
    chk("loop_fail", ctlw, ctl(2, 1, 1, 1, 1, 0, 1, 1, 1));
    tick();
    chk("loop_fail_depth", 32'(depth), 1);
    drv(4'd9, 1'b0, 1'b0, 8'd0);
    chk("loop_pass", ctlw, ctl(0, 1, 1, 1, 0, 0, 1, 1, 1));
    tick();
    chk("loop_pass_depth", 32'(depth), 0);

    for (int i = 1; i <= 5; i++) begin
      drv(4'd1, 1'b0, 1'b0, 8'd0);
      tick();
      chk("ovf_depth", 32'(depth), (i < 4) ? i : 4);
      chk("ovf_flag", 32'(stack_ovf), (i == 5) ? 1 : 0);
    end
    drv(4'd8, 1'b0, 1'b0, 8'd0);
    tick();
    chk("ovf_pop_depth", 32'(depth), 3);
    chk("ovf_sticky", 32'(stack_ovf), 1);

    drv(4'd1, 1'b0, 1'b0, 8'd0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_ctl", ctlw, INIT);
    chk("async_rst_depth", 32'(depth), 0);
    chk("async_rst_ovf", 32'(stack_ovf), 0);
    reset_n = 1'b1;
    tick();
    chk("init_ignores_op", 32'(depth), 0);
    drv(4'd8, 1'b0, 1'b0, 8'd0);
    chk("unf_ctl", ctlw, POPS);
    tick();
    chk("unf_flag", 32'(stack_unf), 1);
    chk("unf_depth", 32'(depth), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
